// File: rtl/jtvigil_vgen.sv
// Video timing generator: pixel enables, H/V raster counters, blanking/sync flags,
// render-line lookahead, with per-frame line-count mode and vertical flip.
module jtvigil_vgen #(
    parameter int W             = 9,
    parameter int CEN_DIV       = 8,
    parameter int HCNT_END      = 383,
    parameter int HB_END        = 9,
    parameter int HB_START      = 265,
    parameter int HS_START      = 304,
    parameter int HS_END        = 336,
    parameter int V_START       = 0,
    parameter int VB_START      = 255,
    parameter int VS_START      = 260,
    parameter int VS_LEN        = 3,
    parameter int VCNT_END_A    = 283,
    parameter int VCNT_END_B    = 263,
    parameter int VRENDER_AHEAD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vmode,
    input  logic         flip,
    output logic         pxl_cen,
    output logic         pxl2_cen,
    output logic [W-1:0] h,
    output logic [W-1:0] v,
    output logic [W-1:0] vrender,
    output logic         hinit,
    output logic         vinit,
    output logic         LHBL,
    output logic         LVBL,
    output logic         HS,
    output logic         VS,
    output logic         vmode_act,
    output logic         flip_act,
    output logic [7:0]   frame_cnt
);

    localparam int CW = $clog2(CEN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CEN_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CEN_DIV / 2 - 1);
    localparam logic [W-1:0]  H_LAST   = W'(HCNT_END);
    localparam logic [W-1:0]  V_FIRST  = W'(V_START);
    localparam logic [W-1:0]  VEND_A   = W'(VCNT_END_A);
    localparam logic [W-1:0]  VEND_B   = W'(VCNT_END_B);

    function automatic logic in_range(input logic [W-1:0] x, input int lo, input int hi);
        return (int'(x) >= lo) && (int'(x) < hi);
    endfunction

    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  h_reg, h_next;
    logic [W-1:0]  vc_reg, vc_next;
    logic [W-1:0]  vend;
    logic [W:0]    vr_sum;
    logic [W-1:0]  vr;
    logic          tick, h_wrap, frame_wrap;
    logic          pxl_cen_reg, pxl2_cen_reg, hinit_reg, vinit_reg;
    logic          lhbl_reg, lvbl_reg, hs_reg, vs_reg;
    logic          vmode_act_reg, flip_act_reg;
    logic [7:0]    frame_cnt_reg;

    assign tick = (cnt_reg == CNT_LAST);

    always_comb begin
        vend       = vmode_act_reg ? VEND_B : VEND_A;
        h_wrap     = (h_reg == H_LAST);
        frame_wrap = h_wrap && (vc_reg == vend);
        h_next     = h_wrap ? '0 : h_reg + 1'b1;
        vc_next    = vc_reg;
        if (h_wrap) begin
            vc_next = frame_wrap ? V_FIRST : vc_reg + 1'b1;
        end
        // One extra bit so the lookahead sum cannot alias before the wrap test
        vr_sum = {1'b0, vc_reg} + (W+1)'(VRENDER_AHEAD);
        if (vr_sum > {1'b0, vend}) begin
            vr = V_FIRST + W'(vr_sum - {1'b0, vend} - 1'b1);
        end else begin
            vr = vr_sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            h_reg         <= '0;
            vc_reg        <= V_FIRST;
            frame_cnt_reg <= '0;
            vmode_act_reg <= 1'b0;
            flip_act_reg  <= 1'b0;
            pxl_cen_reg   <= 1'b0;
            pxl2_cen_reg  <= 1'b0;
            hinit_reg     <= 1'b0;
            vinit_reg     <= 1'b0;
            lhbl_reg      <= in_range('0, HB_END, HB_START);
            hs_reg        <= in_range('0, HS_START, HS_END);
            lvbl_reg      <= in_range(V_FIRST, 0, VB_START);
            vs_reg        <= in_range(V_FIRST, VS_START, VS_START + VS_LEN);
        end else begin
            cnt_reg      <= tick ? '0 : cnt_reg + 1'b1;
            pxl_cen_reg  <= tick;
            pxl2_cen_reg <= tick || (cnt_reg == CNT_HALF);
            hinit_reg    <= tick && h_wrap;
            vinit_reg    <= tick && frame_wrap;
            if (tick) begin
                h_reg    <= h_next;
                vc_reg   <= vc_next;
                // Flags decode the next-state counters so they line up with h/v
                lhbl_reg <= in_range(h_next, HB_END, HB_START);
                hs_reg   <= in_range(h_next, HS_START, HS_END);
                lvbl_reg <= in_range(vc_next, 0, VB_START);
                vs_reg   <= in_range(vc_next, VS_START, VS_START + VS_LEN);
                if (frame_wrap) begin
                    vmode_act_reg <= vmode;
                    flip_act_reg  <= flip;
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign pxl_cen   = pxl_cen_reg;
    assign pxl2_cen  = pxl2_cen_reg;
    assign h         = h_reg;
    assign v         = flip_act_reg ? ~vc_reg : vc_reg;
    assign vrender   = flip_act_reg ? ~vr : vr;
    assign hinit     = hinit_reg;
    assign vinit     = vinit_reg;
    assign LHBL      = lhbl_reg;
    assign LVBL      = lvbl_reg;
    assign HS        = hs_reg;
    assign VS        = vs_reg;
    assign vmode_act = vmode_act_reg;
    assign flip_act  = flip_act_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: doc/jtvigil_vgen.md
# jtvigil_vgen

Parametrised video timing generator for the JTVIGIL video path and later cores. It derives the pixel clock enables from the system clock and runs the H/V raster counters. It generates blanking, sync, render-line lookahead and frame strobes. It adds two behaviours the fixed timer does not have: a frame-selectable line count (55 Hz / 59 Hz mode) and a frame-synchronous vertical flip. It sits at the top of the video block and feeds the scroll, object and colour-mix units.

## Interface
Parameters:
- W, 9, width of h/v counters
- CEN_DIV, 8, clk cycles per pixel; must be even and at least 2
- HCNT_END, 383, last h value
- HB_END, 9, first visible h
- HB_START, 265, first blanked h
- HS_START, 304, first HS pixel
- HS_END, 336, first pixel after HS
- V_START, 0, first line of a frame
- VB_START, 255, first blanked line; blank lasts to frame end
- VS_START, 260, first VS line
- VS_LEN, 3, VS length in lines
- VCNT_END_A, 283, last line when vmode=0 (55 Hz)
- VCNT_END_B, 263, last line when vmode=1 (59 Hz)
- VRENDER_AHEAD, 1, lines by which vrender leads v

Ports:
- clk  in  1  system clock (48 MHz)
- rst_n  in  1  synchronous, active-low reset
- vmode  in  1  requested line-count mode
- flip  in  1  requested vertical flip
- pxl_cen  out  1  pixel enable, one clk per CEN_DIV
- pxl2_cen  out  1  double-rate enable
- h  out  W  horizontal counter
- v  out  W  dump line (flipped when active flip set)
- vrender  out  W  render line (flipped when active flip set)
- hinit  out  1  line-start strobe
- vinit  out  1  frame-start strobe
- LHBL  out  1  active-low H blank
- LVBL  out  1  active-low V blank
- HS  out  1  H sync, active high
- VS  out  1  V sync, active high
- vmode_act  out  1  mode in effect this frame
- flip_act  out  1  flip in effect this frame
- frame_cnt  out  8  frame counter

## Operation
- Divider cnt runs 0..CEN_DIV-1 every clk.
  - pxl_cen=1 when cnt==CEN_DIV-1.
  - pxl2_cen=1 when cnt==CEN_DIV-1 or cnt==CEN_DIV/2-1.
- All raster state updates only on clk cycles with pxl_cen=1.
- h: increments; at HCNT_END it wraps to 0 and line advance occurs.
- Line advance: the internal line vc increments; at vend it wraps to V_START (frame advance).
  - vend = VCNT_END_B if vmode_act else VCNT_END_A.
- Frame advance:
  - vmode_act←vmode and flip_act←flip; these are the only sampling points.
  - frame_cnt increments and wraps 255→0.
- vr = vc+VRENDER_AHEAD. If vr exceeds vend, it wraps as V_START+(vr−vend−1).
- Flip: when flip_act=1, v=~vc and vrender=~vr (bitwise, W bits). Otherwise v=vc and vrender=vr.
- Flags, registered from the next-state counters so they align with h/v:
  - LHBL=1 when HB_END≤h<HB_START.
  - HS=1 when HS_START≤h<HS_END.
  - LVBL=1 when vc<VB_START.
  - VS=1 when VS_START≤vc<VS_START+VS_LEN.
  - VS and LVBL change only together with h wrap.
- hinit: one clk pulse, coincident with the pxl_cen where h becomes 0.
- vinit: one clk pulse, on that same cycle when vc becomes V_START.
- vmode or flip toggling mid-frame has no effect until the next frame advance. Multiple toggles within one frame: only the value at the boundary counts.

## Timing
- Reset (rst_n=0 at a clk edge), next cycle:
  - cnt=0, h=0, vc=V_START, frame_cnt=0.
  - vmode_act=0, flip_act=0.
  - pxl_cen=0, pxl2_cen=0, hinit=0, vinit=0.
  - LHBL=0, HS=0, VS=0.
  - LVBL=1 with defaults; in general reset flags equal the decode of h=0, vc=V_START.
  - v=V_START, vrender=V_START+VRENDER_AHEAD.
- Reset mid-frame aborts the frame immediately with no partial strobes.
- First pxl_cen after release occurs CEN_DIV clks after the first cycle with rst_n=1.
- Counter, flag and strobe outputs change on the same clk edge as pxl_cen=1. There is no extra pipeline latency.
- Line period = (HCNT_END+1)·CEN_DIV clks.
- Frame period = (vend−V_START+1) lines of the frame being drawn.

## Test plan
- Reset, release, defaults:
  - pxl_cen every 8 clks; pxl2_cen every 4 clks.
  - h goes 0..383 then 0; hinit period 3072 clks.
- Blank/sync decode, defaults:
  - LHBL rises at h=9 and falls at h=265.
  - HS high for h=304..335.
  - LVBL low from vc=255 to end of frame.
  - VS high for vc=260..262.
- Mode switch: vmode=1 asserted at vc=100.
  - That frame ends at 283 and vmode_act rises at vinit.
  - Next frame wraps 263→0; vinit spacing changes from 284 to 264 lines.
- Flip: flip=1 at vc=50.
  - v unchanged until frame end.
  - Next frame: v=511 (~0) at vc=0; vrender=510 at vc=0.
- Lookahead wrap with VRENDER_AHEAD=1, vmode_act=0: vc=283 gives vrender=0.
- Reset mid-frame at h=200, vc=120:
  - Next cycle h=0, vc=0, frame_cnt=0, LVBL=1.
  - No hinit/vinit pulse until a full line elapses.
